// File: rtl/gear_shift_controller_if.sv
// Keypad, interlock and gear-code bundle between the keypad front end and the shift controller.
// The master drives the vehicle inputs and the slave (the controller) returns the gear state.
interface gear_shift_controller_if;
  logic       engine_on;
  logic       key_valid;
  logic [3:0] key_code;
  logic       brake_pressed;
  logic [7:0] speed;
  logic [3:0] current_gear;
  logic       shift_busy;
  logic       reject_pulse;
  logic [1:0] reject_code;

  modport master (
    output engine_on, key_valid, key_code, brake_pressed, speed,
    input  current_gear, shift_busy, reject_pulse, reject_code
  );

  modport slave (
    input  engine_on, key_valid, key_code, brake_pressed, speed,
    output current_gear, shift_busy, reject_pulse, reject_code
  );
endinterface

// File: rtl/gear_shift_controller.sv
// Debounces keypad presses into gear requests, enforces brake/speed interlocks and
// models a timed engagement (output reads N) before committing the new gear.
module gear_shift_controller #(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int SHIFT_CYC    = 50000,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gear_shift_controller_if.slave  ctrl_io
);

  localparam logic [0:0] ST_STEADY = 1'b0;
  localparam logic [0:0] ST_ENGAGE = 1'b1;

  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  localparam logic [1:0] REJ_NO_BRAKE = 2'b01;
  localparam logic [1:0] REJ_SPEED    = 2'b10;
  localparam logic [1:0] REJ_INVALID  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DEB_PRE    = CNT_W'(DEBOUNCE_CYC - 2);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);

  // Debounce state
  logic [3:0]       key_q;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             armed_q, armed_d;
  logic             key_same;
  logic             accept;

  // Request pipeline
  logic             req_valid_q, req_valid_d;
  logic [3:0]       req_code_q;

  // Shift FSM and registered outputs
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] eng_cnt_q, eng_cnt_d;
  logic [3:0]       target_q, target_d;
  logic [3:0]       gear_q, gear_d;
  logic             busy_q, busy_d;
  logic             pulse_q, pulse_d;
  logic [1:0]       rcode_q, rcode_d;

  logic             code_ok;
  logic             pair_rd;
  logic             speed_nz;

  // The accept fires on the same edge that stable_cnt reaches DEBOUNCE_CYC-1.
  always_comb begin
    key_same = ctrl_io.key_valid && (ctrl_io.key_code == key_q);

    stable_cnt_d = '0;
    if (key_same) begin
      stable_cnt_d = (stable_cnt_q == CNT_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
    end

    rel_cnt_d = '0;
    if (!ctrl_io.key_valid) begin
      rel_cnt_d = (rel_cnt_q == CNT_MAX) ? rel_cnt_q : rel_cnt_q + 1'b1;
    end

    accept = armed_q && key_same && (stable_cnt_q == DEB_PRE);

    armed_d = armed_q;
    if (accept) begin
      armed_d = 1'b0;
    end else if (!ctrl_io.key_valid && (rel_cnt_q >= DEB_LAST)) begin
      armed_d = 1'b1;
    end

    req_valid_d = accept && ctrl_io.engine_on;
  end

  always_comb begin
    code_ok  = (req_code_q == GEAR_P) || (req_code_q == GEAR_R) ||
               (req_code_q == GEAR_N) || (req_code_q == GEAR_D);
    pair_rd  = ((gear_q == GEAR_R) && (req_code_q == GEAR_D)) ||
               ((gear_q == GEAR_D) && (req_code_q == GEAR_R));
    speed_nz = (ctrl_io.speed != 8'd0);
  end

  // Engine-off outranks engagement completion, which outranks a new request.
  always_comb begin
    state_d   = state_q;
    eng_cnt_d = eng_cnt_q;
    target_d  = target_q;
    gear_d    = gear_q;
    busy_d    = busy_q;
    pulse_d   = 1'b0;
    rcode_d   = rcode_q;

    if (!ctrl_io.engine_on) begin
      state_d   = ST_STEADY;
      gear_d    = GEAR_P;
      busy_d    = 1'b0;
      eng_cnt_d = '0;
    end else if (state_q == ST_ENGAGE) begin
      eng_cnt_d = (eng_cnt_q == CNT_MAX) ? eng_cnt_q : eng_cnt_q + 1'b1;
      if (eng_cnt_q == SHIFT_LAST) begin
        state_d = ST_STEADY;
        gear_d  = target_q;
        busy_d  = 1'b0;
      end
    end else if (req_valid_q) begin
      if (!code_ok) begin
        pulse_d = 1'b1;
        rcode_d = REJ_INVALID;
      end else if (req_code_q == gear_q) begin
        pulse_d = 1'b0;
      end else if ((gear_q == GEAR_P) && !ctrl_io.brake_pressed) begin
        pulse_d = 1'b1;
        rcode_d = REJ_NO_BRAKE;
      end else if (((req_code_q == GEAR_P) || (req_code_q == GEAR_R) || pair_rd) && speed_nz) begin
        pulse_d = 1'b1;
        rcode_d = REJ_SPEED;
      end else begin
        state_d   = ST_ENGAGE;
        eng_cnt_d = '0;
        target_d  = req_code_q;
        gear_d    = GEAR_N;
        busy_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      stable_cnt_q <= '0;
      rel_cnt_q    <= '0;
      armed_q      <= 1'b1;
      req_valid_q  <= 1'b0;
      req_code_q   <= '0;
    end else begin
      key_q        <= ctrl_io.key_code;
      stable_cnt_q <= stable_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      armed_q      <= armed_d;
      req_valid_q  <= req_valid_d;
      if (accept) begin
        req_code_q <= key_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STEADY;
      eng_cnt_q <= '0;
      target_q  <= GEAR_P;
      gear_q    <= GEAR_P;
      busy_q    <= 1'b0;
      pulse_q   <= 1'b0;
      rcode_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      eng_cnt_q <= eng_cnt_d;
      target_q  <= target_d;
      gear_q    <= gear_d;
      busy_q    <= busy_d;
      pulse_q   <= pulse_d;
      rcode_q   <= rcode_d;
    end
  end

  assign ctrl_io.current_gear = gear_q;
  assign ctrl_io.shift_busy   = busy_q;
  assign ctrl_io.reject_pulse = pulse_q;
  assign ctrl_io.reject_code  = rcode_q;

endmodule
